// File: rtl/mem_if_pkg.sv
// Shared widths, FSM state encoding and the default-line pattern for the
// L2-to-memory responder.
package mem_if_pkg;

   localparam int LINE_W = 512;
   localparam int TAG_W  = 18;
   localparam int IDX_W  = 8;
   localparam int WORD_W = 32;
   localparam int WORDS  = LINE_W / WORD_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WBUSY = 2'd1,
      RBUSY = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Word k of a never-written line is {2'b00, index, k, tag}.
   function automatic logic [LINE_W-1:0] default_line(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] index);
      logic [LINE_W-1:0] line;
      line = '0;
      for (int k = 0; k < WORDS; k++) begin
         line[WORD_W*k +: WORD_W] = {2'b00, index, 4'(k), tag};
      end
      return line;
   endfunction

endpackage

// File: rtl/mem_line_store.sv
// Line-granular backing store: synchronous write, combinational read that
// falls back to the default pattern for lines never written since reset.
module mem_line_store #(
   parameter int LINE_W     = mem_if_pkg::LINE_W,
   parameter int TAG_W      = mem_if_pkg::TAG_W,
   parameter int IDX_W      = mem_if_pkg::IDX_W,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [LINE_W-1:0]     wdata_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   input  logic [TAG_W-1:0]      rtag_i,
   input  logic [IDX_W-1:0]      ridx_i,
   output logic [LINE_W-1:0]     rdata_o
);
   import mem_if_pkg::*;

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [LINE_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;

   // Line contents survive reset; only the valid bits are cleared.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[waddr_i] <= 1'b1;
      end
   end

   assign rdata_o = valid_q[raddr_i] ? mem_q[raddr_i] : default_line(rtag_i, ridx_i);

endmodule

// File: rtl/l2_mem_responder.sv
// Main-memory responder for L2 fills and write-backs: programmable latency,
// one-cycle ready pulse, small backing store, completion counters.
module l2_mem_responder #(
   parameter int LINE_W     = mem_if_pkg::LINE_W,
   parameter int TAG_W      = mem_if_pkg::TAG_W,
   parameter int IDX_W      = mem_if_pkg::IDX_W,
   parameter int DEPTH_LOG2 = 6,
   parameter int READ_LAT   = 8,
   parameter int WRITE_LAT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_L2_MEM,
   input  logic              write_L2_MEM,
   input  logic [IDX_W-1:0]  index_L2_MEM,
   input  logic [TAG_W-1:0]  tag_L2_MEM,
   input  logic [TAG_W-1:0]  write_tag_L2_MEM,
   input  logic [LINE_W-1:0] write_data_L2_MEM,
   output logic              ready_MEM_L2,
   output logic [LINE_W-1:0] read_data_MEM_L2,
   output logic [31:0]       rd_count,
   output logic [31:0]       wr_count,
   output logic              proto_err
);
   import mem_if_pkg::*;

   localparam int CNT_W = 16;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] key_q, key_d;
   logic [TAG_W-1:0]      tag_q, tag_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [LINE_W-1:0]     wdata_q, wdata_d;
   logic [LINE_W-1:0]     rdata_q, rdata_d;
   logic                  ready_q, ready_d;
   logic                  perr_q, perr_d;
   logic [31:0]           rdcnt_q, rdcnt_d;
   logic [31:0]           wrcnt_q, wrcnt_d;
   logic                  store_we;
   logic [LINE_W-1:0]     store_rdata;

   mem_line_store #(
      .LINE_W     (LINE_W),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .we_i    (store_we),
      .waddr_i (key_q),
      .wdata_i (wdata_q),
      .raddr_i (key_q),
      .rtag_i  (tag_q),
      .ridx_i  (idx_q),
      .rdata_o (store_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      tag_d    = tag_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      perr_d   = perr_q;
      rdcnt_d  = rdcnt_q;
      wrcnt_d  = wrcnt_q;
      store_we = 1'b0;

      case (state_q)
         IDLE: begin
            // Write-back wins when both requests are raised together.
            if (write_L2_MEM) begin
               key_d   = DEPTH_LOG2'({write_tag_L2_MEM, index_L2_MEM});
               wdata_d = write_data_L2_MEM;
               cnt_d   = CNT_W'(WRITE_LAT - 1);
               state_d = WBUSY;
            end else if (read_L2_MEM) begin
               key_d   = DEPTH_LOG2'({tag_L2_MEM, index_L2_MEM});
               tag_d   = tag_L2_MEM;
               idx_d   = index_L2_MEM;
               cnt_d   = CNT_W'(READ_LAT - 1);
               state_d = RBUSY;
            end
         end
         WBUSY: begin
            if (!write_L2_MEM) begin
               perr_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               ready_d  = 1'b1;
               store_we = 1'b1;
               wrcnt_d  = wrcnt_q + 32'd1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RBUSY: begin
            if (!read_L2_MEM) begin
               perr_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               ready_d = 1'b1;
               rdata_d = store_rdata;
               rdcnt_d = rdcnt_q + 32'd1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            // Guard cycle: L2 is still dropping its request after the pulse.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         perr_q  <= 1'b0;
         rdcnt_q <= '0;
         wrcnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         perr_q  <= perr_d;
         rdcnt_q <= rdcnt_d;
         wrcnt_q <= wrcnt_d;
      end
   end

   // Request payload is only meaningful while a transaction is in flight.
   always_ff @(posedge clk) begin
      key_q   <= key_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   assign ready_MEM_L2     = ready_q;
   assign read_data_MEM_L2 = rdata_q;
   assign rd_count         = rdcnt_q;
   assign wr_count         = wrcnt_q;
   assign proto_err        = perr_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: latency, write-back/readback,
// arbitration, request drop, reset abort and key aliasing.
module tb_l2_mem_responder;

   logic         clk = 1'b0;
   logic         rst;
   logic         read_L2_MEM;
   logic         write_L2_MEM;
   logic [7:0]   index_L2_MEM;
   logic [17:0]  tag_L2_MEM;
   logic [17:0]  write_tag_L2_MEM;
   logic [511:0] write_data_L2_MEM;
   logic         ready_MEM_L2;
   logic [511:0] read_data_MEM_L2;
   logic [31:0]  rd_count;
   logic [31:0]  wr_count;
   logic         proto_err;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;
   int lat;
   int p0;

   l2_mem_responder #(
      .LINE_W     (512),
      .TAG_W      (18),
      .IDX_W      (8),
      .DEPTH_LOG2 (6),
      .READ_LAT   (8),
      .WRITE_LAT  (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .read_L2_MEM       (read_L2_MEM),
      .write_L2_MEM      (write_L2_MEM),
      .index_L2_MEM      (index_L2_MEM),
      .tag_L2_MEM        (tag_L2_MEM),
      .write_tag_L2_MEM  (write_tag_L2_MEM),
      .write_data_L2_MEM (write_data_L2_MEM),
      .ready_MEM_L2      (ready_MEM_L2),
      .read_data_MEM_L2  (read_data_MEM_L2),
      .rd_count          (rd_count),
      .wr_count          (wr_count),
      .proto_err         (proto_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ready_MEM_L2) pulses++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word(input int k);
      return read_data_MEM_L2[32*k +: 32];
   endfunction

   // Request must already be raised; first edge is the accept edge.
   task automatic wait_ready(output int l);
      l = -1;
      tick();
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ready_MEM_L2) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic do_read(input logic [7:0] idx, input logic [17:0] tag, input string name);
      int l;
      index_L2_MEM = idx;
      tag_L2_MEM   = tag;
      read_L2_MEM  = 1'b1;
      wait_ready(l);
      chk({name, "_lat"}, 32'(l), 32'd8);
      read_L2_MEM = 1'b0;
      tick();
      chk({name, "_pulse1"}, {31'd0, ready_MEM_L2}, 32'd0);
   endtask

   task automatic do_write(input logic [7:0] idx, input logic [17:0] wtag,
                           input logic [31:0] base, input string name);
      int l;
      index_L2_MEM     = idx;
      write_tag_L2_MEM = wtag;
      for (int k = 0; k < 16; k++) write_data_L2_MEM[32*k +: 32] = base + 32'(k);
      write_L2_MEM = 1'b1;
      wait_ready(l);
      chk({name, "_lat"}, 32'(l), 32'd4);
      write_L2_MEM = 1'b0;
      tick();
      chk({name, "_pulse1"}, {31'd0, ready_MEM_L2}, 32'd0);
   endtask

   initial begin
      rst               = 1'b1;
      read_L2_MEM       = 1'b0;
      write_L2_MEM      = 1'b0;
      index_L2_MEM      = '0;
      tag_L2_MEM        = '0;
      write_tag_L2_MEM  = '0;
      write_data_L2_MEM = '0;
      tick();
      tick();
      chk("rst_ready", {31'd0, ready_MEM_L2}, 32'd0);
      chk("rst_rdata", word(0), 32'd0);
      chk("rst_rdcnt", rd_count, 32'd0);
      chk("rst_wrcnt", wr_count, 32'd0);
      chk("rst_perr", {31'd0, proto_err}, 32'd0);
      rst = 1'b0;
      tick();

      // Cold read returns the default pattern
      do_read(8'h05, 18'h00003, "t1");
      chk("t1_w0", word(0), 32'h0140_0003);
      chk("t1_w15", word(15), 32'h017C_0003);
      chk("t1_rdcnt", rd_count, 32'd1);

      // Write-back then readback
      do_write(8'h05, 18'h00003, 32'hA5A5_0000, "t2w");
      chk("t2_wrcnt", wr_count, 32'd1);
      do_read(8'h05, 18'h00003, "t2r");
      chk("t2_w3", word(3), 32'hA5A5_0003);
      chk("t2_w0", word(0), 32'hA5A5_0000);
      tick();
      chk("t2_hold", word(3), 32'hA5A5_0003);
      chk("t2_rdcnt", rd_count, 32'd2);

      // Simultaneous read and write: write first
      index_L2_MEM     = 8'h10;
      tag_L2_MEM       = 18'h0;
      write_tag_L2_MEM = 18'h0;
      for (int k = 0; k < 16; k++) write_data_L2_MEM[32*k +: 32] = 32'h1111_0000 + 32'(k);
      p0           = pulses;
      write_L2_MEM = 1'b1;
      read_L2_MEM  = 1'b1;
      wait_ready(lat);
      chk("t3_wlat", 32'(lat), 32'd4);
      chk("t3_wrcnt", wr_count, 32'd2);
      chk("t3_rdcnt_mid", rd_count, 32'd2);
      write_L2_MEM = 1'b0;
      tick();
      chk("t3_guard", {31'd0, ready_MEM_L2}, 32'd0);
      wait_ready(lat);
      chk("t3_rlat", 32'(lat), 32'd8);
      read_L2_MEM = 1'b0;
      tick();
      chk("t3_w7", word(7), 32'h1111_0007);
      chk("t3_pulses", 32'(pulses - p0), 32'd2);
      chk("t3_rdcnt", rd_count, 32'd3);

      // Read dropped mid-service
      index_L2_MEM = 8'h20;
      tag_L2_MEM   = 18'h00002;
      p0           = pulses;
      read_L2_MEM  = 1'b1;
      tick();
      tick();
      tick();
      read_L2_MEM = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk("t4_nopulse", 32'(pulses - p0), 32'd0);
      chk("t4_perr", {31'd0, proto_err}, 32'd1);
      chk("t4_rdcnt", rd_count, 32'd3);
      do_read(8'h20, 18'h00002, "t4r");
      chk("t4_w1", word(1), 32'h0804_0002);
      chk("t4_rdcnt2", rd_count, 32'd4);
      chk("t4_sticky", {31'd0, proto_err}, 32'd1);

      // Reset two cycles after a write accept
      index_L2_MEM     = 8'h07;
      write_tag_L2_MEM = 18'h00005;
      for (int k = 0; k < 16; k++) write_data_L2_MEM[32*k +: 32] = 32'h7777_0000 + 32'(k);
      p0           = pulses;
      write_L2_MEM = 1'b1;
      tick();
      tick();
      tick();
      rst          = 1'b1;
      write_L2_MEM = 1'b0;
      #1;
      chk("t5_ready", {31'd0, ready_MEM_L2}, 32'd0);
      chk("t5_rdcnt", rd_count, 32'd0);
      chk("t5_wrcnt", wr_count, 32'd0);
      chk("t5_perr", {31'd0, proto_err}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("t5_nopulse", 32'(pulses - p0), 32'd0);
      do_read(8'h07, 18'h00005, "t5r");
      chk("t5_w2", word(2), 32'h01C8_0005);
      do_read(8'h05, 18'h00003, "t5v");
      chk("t5_cleared", word(3), 32'h014C_0003);
      chk("t5_rdcnt2", rd_count, 32'd2);

      // Key aliasing: tag/index bits above the key width are ignored
      do_write(8'h41, 18'h00000, 32'hC0DE_0000, "t6w");
      chk("t6_wrcnt", wr_count, 32'd1);
      do_read(8'h01, 18'h00001, "t6r");
      chk("t6_w9", word(9), 32'hC0DE_0009);
      chk("t6_rdcnt", rd_count, 32'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
